sfr_shift4: RTL and testbench



---
 rtl/sfr_shift4_pkg.sv | 6 +
 rtl/sfr_stage.sv | 20 ++
 rtl/sfr_shift4.sv | 38 +++
 tb/tb_sfr_shift4.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sfr_shift4_pkg.sv
// Shared constants for the sfr_shift4 serial-in, parallel-out delay line.
package sfr_shift4_pkg;

  localparam int NSTAGES = 4;

endpackage

// File: rtl/sfr_stage.sv
// One delay stage: WIDTH-bit flop with asynchronous active-low clear.
// Latency 1 cycle; no backpressure, loads on every rising edge.
module sfr_stage #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/sfr_shift4.sv
// Four-stage shift register with a tap after every stage (delays of 1..4 cycles).
// Latency 1 cycle to o_q0, 4 cycles to o_q3; no backpressure, shifts every edge.
module sfr_shift4
  import sfr_shift4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q0,
  output logic [WIDTH-1:0] o_q1,
  output logic [WIDTH-1:0] o_q2,
  output logic [WIDTH-1:0] o_q3
);

  // chain[0] is the serial input; chain[k+1] is the output of stage k.
  logic [WIDTH-1:0] chain [NSTAGES+1];

  assign chain[0] = i_d;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    sfr_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (chain[k]),
      .o_q     (chain[k+1])
    );
  end

  assign o_q0 = chain[1];
  assign o_q1 = chain[2];
  assign o_q2 = chain[3];
  assign o_q3 = chain[4];

endmodule

// File: tb/tb_sfr_shift4.sv
// Bench for sfr_shift4: a 1-bit and an 8-bit instance checked against a sample-history model.
module tb_sfr_shift4;

  logic       clk;
  logic       rst_n;
  logic       d1;
  logic [7:0] d8;
  logic       a_q0, a_q1, a_q2, a_q3;
  logic [7:0] b_q0, b_q1, b_q2, b_q3;

  int checks = 0;
  int errors = 0;

  sfr_shift4 #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(d1),
    .o_q0(a_q0), .o_q1(a_q1), .o_q2(a_q2), .o_q3(a_q3)
  );

  sfr_shift4 #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(d8),
    .o_q0(b_q0), .o_q1(b_q1), .o_q2(b_q2), .o_q3(b_q3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: every value sampled since the last reset, oldest first.
  // The tap delayed by k+1 cycles shows the (k+1)-th most recent sample, or zero.
  logic [7:0] hist1[$];
  logic [7:0] hist8[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1.delete();
      hist8.delete();
    end else begin
      hist1.push_back({7'd0, d1});
      hist8.push_back(d8);
    end
  end

  function automatic logic [7:0] expect1(int k);
    int n = hist1.size();
    return (n > k) ? hist1[n-1-k] : 8'd0;
  endfunction

  function automatic logic [7:0] expect8(int k);
    int n = hist8.size();
    return (n > k) ? hist8[n-1-k] : 8'd0;
  endfunction

  // Compare process: every falling edge, all taps of both instances.
  always @(negedge clk) begin
    logic [7:0] act1 [4];
    logic [7:0] act8 [4];
    act1[0] = {7'd0, a_q0}; act1[1] = {7'd0, a_q1};
    act1[2] = {7'd0, a_q2}; act1[3] = {7'd0, a_q3};
    act8[0] = b_q0; act8[1] = b_q1; act8[2] = b_q2; act8[3] = b_q3;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act1[k] !== expect1(k)) begin
        errors++;
        $display("FAIL model_w1 q%0d at %0t: got %h want %h", k, $time, act1[k], expect1(k));
      end
      checks++;
      if (act8[k] !== expect8(k)) begin
        errors++;
        $display("FAIL model_w8 q%0d at %0t: got %h want %h", k, $time, act8[k], expect8(k));
      end
    end
  end

  task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] taps1();
    return {a_q3, a_q2, a_q1, a_q0};
  endfunction

  task automatic drive(input logic v1, input logic [7:0] v8);
    @(negedge clk);
    d1 = v1;
    d8 = v8;
  endtask

  logic [3:0] rel_exp   [4];
  logic [3:0] pulse_exp [5];
  logic [7:0] lat_d8    [4];
  logic       lat_d1    [4];

  initial begin
    rel_exp   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    pulse_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    lat_d1    = '{1'b1, 1'b0, 1'b1, 1'b1};
    lat_d8    = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

    // Reset held with input high: all taps stay zero.
    rst_n = 1'b0;
    d1    = 1'b1;
    d8    = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_lit("reset_hold_w1", {28'd0, taps1()}, 32'd0);
    check_lit("reset_hold_w8", {b_q3, b_q2, b_q1, b_q0}, 32'd0);

    // Release with input held high: ones fill in from q0.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_lit("release_fill", {28'd0, taps1()}, {28'd0, rel_exp[i]});
    end

    // Flush, then a single pulse walks through.
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00);
    drive(1'b1, 8'h01);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_lit("single_pulse", {28'd0, taps1()}, {28'd0, pulse_exp[i]});
      drive(1'b0, 8'h00);
    end

    // Alternating stream starting with 1; samples 1,0,1,0 give q3..q0 = 1010.
    for (int i = 0; i < 4; i++) drive(i[0] ? 1'b0 : 1'b1, i[0] ? 8'h55 : 8'hAA);
    @(posedge clk);
    #1;
    check_lit("alternate_4", {28'd0, taps1()}, 32'h0000_000A);
    for (int i = 0; i < 3; i++) drive(i[0] ? 1'b0 : 1'b1, i[0] ? 8'h55 : 8'hAA);
    @(posedge clk);
    #1;
    check_lit("alternate_7", {28'd0, taps1()}, 32'h0000_0005);

    // Fill with ones, then drop reset between edges.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hFF);
    @(posedge clk);
    #1;
    check_lit("fill_ones", {28'd0, taps1()}, 32'h0000_000F);
    #1;
    rst_n = 1'b0;
    #1;
    check_lit("async_reset_w1", {28'd0, taps1()}, 32'd0);
    check_lit("async_reset_w8", {b_q3, b_q2, b_q1, b_q0}, 32'd0);
    @(posedge clk);
    #1;
    check_lit("reset_over_edge", {b_q3, b_q2, b_q1, b_q0}, 32'd0);

    // Latency / width: 1,0,1,1 and A5,3C,FF,00 on consecutive edges.
    @(negedge clk);
    rst_n = 1'b1;
    d1    = lat_d1[0];
    d8    = lat_d8[0];
    for (int i = 1; i < 4; i++) drive(lat_d1[i], lat_d8[i]);
    @(posedge clk);
    #1;
    check_lit("latency_w1", {28'd0, taps1()}, 32'h0000_000B);
    check_lit("latency_w8", {b_q3, b_q2, b_q1, b_q0}, 32'hA53C_FF00);

    // One more edge: A5 falls off the end.
    drive(1'b0, 8'h77);
    @(posedge clk);
    #1;
    check_lit("discard_w8", {b_q3, b_q2, b_q1, b_q0}, 32'h3CFF_0077);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
